// File: rtl/hex_dirty_compactor.sv
// hex_dirty_compactor
//   Takes one 10-lane hex bundle per handshake. It keeps the lanes that are dirty and
//   inside the map, and emits them one per cycle, lowest lane first. Each emitted hex
//   carries a linear framebuffer address.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   bundle handshake; in_q/in_r/in_depth/in_dirty hold the lane data
//   out_valid/out_ready hex handshake
//   out_q/out_r/out_depth/out_lane/out_addr/out_last   selected hex
//   drop_count          saturating count of dirty hexes that fell outside the map
//   busy                pending mask non-zero
//
// The pending mask is the only control state: zero means idle, non-zero means emitting.
module hex_dirty_compactor #(
    parameter int unsigned LANES  = 10,
    parameter int unsigned QW     = 16,
    parameter int unsigned MAP_W  = 64,
    parameter int unsigned MAP_H  = 64,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [QW-1:0]     in_q     [LANES],
    input  logic signed [QW-1:0]     in_r     [LANES],
    input  logic        [7:0]        in_depth [LANES],
    input  logic        [LANES-1:0]  in_dirty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [QW-1:0]     out_q,
    output logic signed [QW-1:0]     out_r,
    output logic        [7:0]        out_depth,
    output logic        [3:0]        out_lane,
    output logic        [ADDR_W-1:0] out_addr,
    output logic                     out_last,
    output logic        [15:0]       drop_count,
    output logic                     busy
);

    localparam logic signed [QW:0]     ColLimit = (QW+1)'(MAP_W);
    localparam logic signed [QW:0]     RowLimit = (QW+1)'(MAP_H);
    localparam logic [ADDR_W-1:0]      AddrMapW = ADDR_W'(MAP_W);

    logic signed [QW-1:0] r_q     [LANES];
    logic signed [QW-1:0] r_r     [LANES];
    logic        [7:0]    r_depth [LANES];
    logic [LANES-1:0]     r_pending;
    logic [15:0]          r_drop_count;

    logic [LANES-1:0]     w_inrange;
    logic [15:0]          w_drop_n;
    logic [16:0]          w_drop_sum;
    logic [3:0]           w_sel;
    logic                 w_single;
    logic                 w_out_fire;
    logic                 w_in_fire;
    logic signed [QW:0]   w_sel_col;
    logic [ADDR_W-1:0]    w_row_a;
    logic [ADDR_W-1:0]    w_col_a;

    // Axial to offset column: col = q + floor(r / 2), one bit wider so it cannot wrap.
    function automatic logic signed [QW:0] col_of(logic signed [QW-1:0] q,
                                                  logic signed [QW-1:0] r);
        logic signed [QW:0] qe;
        logic signed [QW:0] re;
        qe = {q[QW-1], q};
        re = {r[QW-1], r};
        return qe + (re >>> 1);
    endfunction

    // Per-lane map range check and drop popcount for the incoming bundle.
    always_comb begin
        logic signed [QW:0] col;
        logic signed [QW:0] row;
        w_inrange = '0;
        w_drop_n  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            col = col_of(in_q[i], in_r[i]);
            row = {in_r[i][QW-1], in_r[i]};
            w_inrange[i] = !row[QW] && (row < RowLimit) && !col[QW] && (col < ColLimit);
            w_drop_n = w_drop_n + 16'(in_dirty[i] && !w_inrange[i]);
        end
        w_drop_sum = {1'b0, r_drop_count} + {1'b0, w_drop_n};
    end

    // Lowest pending lane; defaults to lane 0 when idle so outputs show reset-state fields.
    always_comb begin
        w_sel = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = 4'(i);
            end
        end
        w_single   = (r_pending != '0) && ((r_pending & (r_pending - LANES'(1))) == '0);
        w_out_fire = (r_pending != '0) && out_ready;
        in_ready   = (r_pending == '0) || (w_out_fire && w_single);
        w_in_fire  = in_valid && in_ready;
        w_sel_col  = col_of(r_q[w_sel], r_r[w_sel]);
        w_row_a    = ADDR_W'(r_r[w_sel]);
        w_col_a    = ADDR_W'(w_sel_col);
    end

    always_comb begin
        out_valid  = (r_pending != '0);
        out_last   = w_single;
        out_q      = r_q[w_sel];
        out_r      = r_r[w_sel];
        out_depth  = r_depth[w_sel];
        out_lane   = w_sel;
        out_addr   = w_row_a * AddrMapW + w_col_a;
        drop_count = r_drop_count;
        busy       = (r_pending != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_drop_count <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                r_q[i]     <= '0;
                r_r[i]     <= '0;
                r_depth[i] <= '0;
            end
        end else begin
            // A capture overrides the clear of a retiring last lane.
            if (w_in_fire) begin
                r_pending    <= in_dirty & w_inrange;
                r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
                for (int i = 0; i < int'(LANES); i++) begin
                    r_q[i]     <= in_q[i];
                    r_r[i]     <= in_r[i];
                    r_depth[i] <= in_depth[i];
                end
            end else if (w_out_fire) begin
                r_pending <= r_pending & ~(LANES'(1) << w_sel);
            end
        end
    end

endmodule

// File: tb/tb_hex_dirty_compactor.sv
// Directed bench for hex_dirty_compactor with hand-computed expectations.
module tb_hex_dirty_compactor;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] tb_q     [10];
    logic signed [15:0] tb_r     [10];
    logic        [7:0]  tb_depth [10];
    logic        [9:0]  tb_dirty;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_q;
    logic signed [15:0] out_r;
    logic        [7:0]  out_depth;
    logic        [3:0]  out_lane;
    logic        [11:0] out_addr;
    logic               out_last;
    logic        [15:0] drop_count;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;

    hex_dirty_compactor dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_q       (tb_q),
        .in_r       (tb_r),
        .in_depth   (tb_depth),
        .in_dirty   (tb_dirty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_r      (out_r),
        .out_depth  (out_depth),
        .out_lane   (out_lane),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_hex(input string tag, input int lane, input int addr, input bit last);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " lane"},  32'(out_lane),  32'(lane));
        check({tag, " addr"},  32'(out_addr),  32'(addr));
        check({tag, " last"},  32'(out_last),  32'(last));
    endtask

    // Fill lanes with q = lane, r = r_all, depth = lane.
    task automatic set_bundle(input logic [9:0] dirty, input int r_all);
        for (int i = 0; i < 10; i++) begin
            tb_q[i]     = 16'(i);
            tb_r[i]     = 16'(r_all);
            tb_depth[i] = 8'(i);
        end
        tb_dirty = dirty;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_lanes[8];
        int idx;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_bundle(10'd0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst out_valid", 32'(out_valid), 0);
        check("rst in_ready",  32'(in_ready),  1);
        check("rst busy",      32'(busy),      0);
        check("rst drop",      32'(drop_count), 0);
        check("rst addr",      32'(out_addr),  0);
        check("rst last",      32'(out_last),  0);

        // Lanes 1, 4, 9 at r = 2 -> addr 130, 133, 138
        set_bundle(10'b10_0001_0010, 2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_hex("t1 h0", 1, 130, 0);
        check("t1 h0 q",     32'(out_q),     1);
        check("t1 h0 r",     32'(out_r),     2);
        check("t1 h0 depth", 32'(out_depth), 1);
        check("t1 h0 busy",  32'(busy),      1);
        check("t1 h0 ready", 32'(in_ready),  0);
        tick();
        expect_hex("t1 h1", 4, 133, 0);
        check("t1 h1 ready", 32'(in_ready), 0);
        tick();
        expect_hex("t1 h2", 9, 138, 1);
        check("t1 h2 ready", 32'(in_ready), 1);
        tick();
        check("t1 idle valid", 32'(out_valid), 0);
        check("t1 idle busy",  32'(busy),      0);

        // Back-to-back: A lanes 2,3 r=0 (addr 2,3); B lanes 0,7 r=1 (addr 64,71)
        set_bundle(10'b00_0000_1100, 0);
        in_valid = 1'b1;
        tick();
        set_bundle(10'b00_1000_0001, 1);
        expect_hex("t2 a0", 2, 2, 0);
        check("t2 a0 ready", 32'(in_ready), 0);
        tick();
        expect_hex("t2 a1", 3, 3, 1);
        check("t2 a1 ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        expect_hex("t2 b0", 0, 64, 0);
        tick();
        expect_hex("t2 b1", 7, 71, 1);
        tick();
        check("t2 idle valid", 32'(out_valid), 0);

        // All dirty; lane 0 has r = -1, lane 5 has q = 70 -> two drops
        set_bundle(10'h3FF, 0);
        tb_r[0] = -16'sd1;
        tb_q[5] = 16'sd70;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3 drop", 32'(drop_count), 2);
        exp_lanes = '{1, 2, 3, 4, 6, 7, 8, 9};
        for (int k = 0; k < 8; k++) begin
            expect_hex($sformatf("t3 h%0d", k), exp_lanes[k], exp_lanes[k], k == 7);
            tick();
        end
        check("t3 idle valid", 32'(out_valid), 0);

        // Clean bundle absorbed, next one accepted straight after.
        set_bundle(10'd0, 0);
        in_valid = 1'b1;
        tick();
        check("t4 clean valid", 32'(out_valid), 0);
        check("t4 clean ready", 32'(in_ready),  1);
        check("t4 drop",        32'(drop_count), 2);
        // lane 6: q = 3, r = 3 -> col 4, addr 196
        set_bundle(10'b00_0100_0000, 3);
        tb_q[6] = 16'sd3;
        tick();
        in_valid = 1'b0;
        expect_hex("t4 next", 6, 196, 1);
        tick();
        check("t4 idle valid", 32'(out_valid), 0);

        // Stall toggling: lanes 0,5,8 at r = 4 -> addr 258, 263, 266
        set_bundle(10'b01_0010_0001, 4);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_lanes[0] = 0;
        exp_lanes[1] = 5;
        exp_lanes[2] = 8;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            out_ready = c[0];
            #1;
            expect_hex($sformatf("t5 c%0d", c), exp_lanes[idx], 258 + exp_lanes[idx], idx == 2);
            check($sformatf("t5 c%0d ready", c), 32'(in_ready), 32'(out_ready && idx == 2));
            if (out_ready) idx++;
            tick();
        end
        out_ready = 1'b1;
        check("t5 idle valid", 32'(out_valid), 0);

        // Saturation: 6553 bundles of 10 drops take the counter from 2 to 65532
        set_bundle(10'h3FF, -5);
        in_valid = 1'b1;
        repeat (6553) @(posedge clk);
        #1;
        check("t6 drop pre", 32'(drop_count), 65532);
        check("t6 ready",    32'(in_ready),   1);
        tick();
        check("t6 drop clamp", 32'(drop_count), 65535);
        tick();
        check("t6 drop hold", 32'(drop_count), 65535);

        // Reset mid-bundle
        set_bundle(10'b00_0000_0111, 0);
        tick();
        in_valid = 1'b0;
        expect_hex("t6 pre-rst", 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6 rst valid", 32'(out_valid),  0);
        check("t6 rst drop",  32'(drop_count), 0);
        check("t6 rst ready", 32'(in_ready),   1);
        check("t6 rst busy",  32'(busy),       0);
        check("t6 rst addr",  32'(out_addr),   0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
